// File: rtl/axis_pkg.sv
// Shared AXI-Stream types and width helpers for the stream FIFO and its beat storage.
package axis_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_DEST_W = 2;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic                   last;
    logic [AXIS_DEST_W-1:0] dest;
  } axis_beat_t;

  function automatic int axis_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int axis_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int axis_beat_w(input int data_w, input int dest_w);
    return data_w + dest_w + 1;
  endfunction

endpackage

// File: rtl/axis_beat_ram.sv
// DEPTH x beat register file: one write port, one asynchronous read port, synchronous clear.
module axis_beat_ram
  import axis_pkg::*;
#(
  parameter int W     = axis_beat_w(AXIS_DATA_W, AXIS_DEST_W),
  parameter int DEPTH = 4,
  parameter int AW    = axis_ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read straight from the flops so the head beat is stable while the sink stalls.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_stream_fifo.sv
// AXI-Stream FIFO with optional store-and-forward gating on tlast and an oversize-packet flag.
module axis_stream_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = AXIS_DATA_W,
  parameter int DEST_WIDTH  = AXIS_DEST_W,
  parameter int DEPTH       = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [DEST_WIDTH-1:0]      s_axis_tdest,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [DEST_WIDTH-1:0]      m_axis_tdest,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       pkt_oversize
);

  localparam int PTR_W  = axis_ptr_w(DEPTH);
  localparam int CNT_W  = axis_cnt_w(DEPTH);
  localparam int BEAT_W = axis_beat_w(DATA_WIDTH, DEST_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [DEST_WIDTH-1:0] dest;
  } beat_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d, pkt_cnt_q, pkt_cnt_d;
  logic             oversize_q, oversize_d;
  logic             full, push, pop, pkt_release;
  beat_t            wr_beat, rd_beat;
  logic [BEAT_W-1:0] rd_word;

  // Handshake: a beat moves on a side only in a cycle where valid and ready are both high;
  // valid never waits for ready, and s_axis_tready depends on stored occupancy only.
  assign full          = (occ_q == CNT_W'(DEPTH));
  assign s_axis_tready = !full && !areset;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // In store-and-forward mode a full FIFO with no complete packet must still drain.
  assign pkt_release   = (PACKET_MODE == 0) || (pkt_cnt_q != '0) || full;
  assign m_axis_tvalid = (occ_q != '0) && pkt_release;

  assign wr_beat = '{data: s_axis_tdata, last: s_axis_tlast, dest: s_axis_tdest};
  assign rd_beat = beat_t'(rd_word);

  assign m_axis_tdata = rd_beat.data;
  assign m_axis_tlast = rd_beat.last;
  assign m_axis_tdest = rd_beat.dest;
  assign occupancy    = occ_q;
  assign pkt_oversize = oversize_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    occ_d      = occ_q;
    pkt_cnt_d  = pkt_cnt_q;
    oversize_d = oversize_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    case ({push && s_axis_tlast, pop && m_axis_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    if ((PACKET_MODE != 0) && full && (pkt_cnt_q == '0)) oversize_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pkt_cnt_q  <= '0;
      oversize_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pkt_cnt_q  <= pkt_cnt_d;
      oversize_q <= oversize_d;
    end
  end

  axis_beat_ram #(
    .W     (BEAT_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (aclk),
    .rst_i   (areset),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench: a cut-through instance and a store-and-forward instance on a shared clock/reset.
module tb_axis_stream_fifo;

  logic        clk = 1'b0;
  logic        areset;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  // cut-through instance
  logic [63:0] c_s_tdata, c_m_tdata;
  logic        c_s_tvalid, c_s_tready, c_s_tlast, c_m_tvalid, c_m_tready, c_m_tlast, c_ovs;
  logic [1:0]  c_s_tdest, c_m_tdest;
  logic [2:0]  c_occ;
  // store-and-forward instance
  logic [63:0] p_s_tdata, p_m_tdata;
  logic        p_s_tvalid, p_s_tready, p_s_tlast, p_m_tvalid, p_m_tready, p_m_tlast, p_ovs;
  logic [1:0]  p_s_tdest, p_m_tdest;
  logic [2:0]  p_occ;

  always #5 clk = ~clk;

  axis_stream_fifo #(.DATA_WIDTH(64), .DEST_WIDTH(2), .DEPTH(4), .PACKET_MODE(0)) u_ct (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(c_s_tdata), .s_axis_tvalid(c_s_tvalid), .s_axis_tready(c_s_tready),
    .s_axis_tlast(c_s_tlast), .s_axis_tdest(c_s_tdest),
    .m_axis_tdata(c_m_tdata), .m_axis_tvalid(c_m_tvalid), .m_axis_tready(c_m_tready),
    .m_axis_tlast(c_m_tlast), .m_axis_tdest(c_m_tdest),
    .occupancy(c_occ), .pkt_oversize(c_ovs)
  );

  axis_stream_fifo #(.DATA_WIDTH(64), .DEST_WIDTH(2), .DEPTH(4), .PACKET_MODE(1)) u_pm (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(p_s_tdata), .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready),
    .s_axis_tlast(p_s_tlast), .s_axis_tdest(p_s_tdest),
    .m_axis_tdata(p_m_tdata), .m_axis_tvalid(p_m_tvalid), .m_axis_tready(p_m_tready),
    .m_axis_tlast(p_m_tlast), .m_axis_tdest(p_m_tdest),
    .occupancy(p_occ), .pkt_oversize(p_ovs)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    c_s_tvalid = 0; c_s_tdata = '0; c_s_tlast = 0; c_s_tdest = '0; c_m_tready = 0;
    p_s_tvalid = 0; p_s_tdata = '0; p_s_tlast = 0; p_s_tdest = '0; p_m_tready = 0;
    tick(); tick();
    checks++; if (c_s_tready !== 1'b0 || p_s_tready !== 1'b0) begin errors++;
      $display("FAIL reset_tready_low got %b/%b expected 0/0", c_s_tready, p_s_tready); end
    areset = 1'b0;
    #1;
    checks++; if (c_s_tready !== 1'b1 || p_s_tready !== 1'b1) begin errors++;
      $display("FAIL reset_tready_high got %b/%b expected 1/1", c_s_tready, p_s_tready); end
    checks++; if (c_m_tvalid !== 1'b0 || p_m_tvalid !== 1'b0) begin errors++;
      $display("FAIL reset_tvalid got %b/%b expected 0/0", c_m_tvalid, p_m_tvalid); end
    checks++; if (c_m_tdata !== 64'h0 || c_m_tlast !== 1'b0 || c_m_tdest !== 2'd0) begin errors++;
      $display("FAIL reset_head got %h/%b/%0d expected 0/0/0", c_m_tdata, c_m_tlast, c_m_tdest); end
    checks++; if (c_occ !== 3'd0 || p_occ !== 3'd0 || c_ovs !== 1'b0 || p_ovs !== 1'b0) begin errors++;
      $display("FAIL reset_occ got %0d/%0d ovs %b/%b expected 0/0 ovs 0/0", c_occ, p_occ, c_ovs, p_ovs); end
    tick();
  endtask

  // 0x11..0x14 with tlast on 0x14, sink always ready: each beat appears one cycle after it is offered.
  task automatic test_cut_through();
    c_m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_s_tvalid = 1'b1; c_s_tdata = 64'h11 + 64'(i); c_s_tlast = (i == 3); c_s_tdest = 2'(i);
      #1;
      checks++;
      if (i == 0) begin
        if (c_m_tvalid !== 1'b0) begin errors++;
          $display("FAIL ct_no_same_cycle got tvalid %b expected 0", c_m_tvalid); end
      end else if (c_m_tvalid !== 1'b1 || c_m_tdata !== 64'h11 + 64'(i - 1) ||
                   c_m_tdest !== 2'(i - 1) || c_m_tlast !== 1'b0 || c_occ !== 3'd1) begin
        errors++;
        $display("FAIL ct_beat%0d got v%b %h d%0d l%b occ%0d expected v1 %h d%0d l0 occ1",
                 i, c_m_tvalid, c_m_tdata, c_m_tdest, c_m_tlast, c_occ, 64'h11 + 64'(i - 1), i - 1);
      end
      tick();
    end
    c_s_tvalid = 1'b0;
    checks++; if (c_m_tvalid !== 1'b1 || c_m_tdata !== 64'h14 || c_m_tlast !== 1'b1 || c_m_tdest !== 2'd3) begin
      errors++; $display("FAIL ct_last got v%b %h l%b d%0d expected v1 14 l1 d3",
                         c_m_tvalid, c_m_tdata, c_m_tlast, c_m_tdest); end
    tick();
    checks++; if (c_m_tvalid !== 1'b0 || c_occ !== 3'd0) begin errors++;
      $display("FAIL ct_empty got v%b occ%0d expected v0 occ0", c_m_tvalid, c_occ); end
  endtask

  // Sink stalled: four beats fill the FIFO, the fifth is held at the input.
  task automatic test_fill();
    c_m_tready = 1'b0;
    c_s_tlast = 1'b0; c_s_tdest = 2'd1;
    for (int i = 0; i < 5; i++) begin
      c_s_tvalid = 1'b1; c_s_tdata = 64'h21 + 64'(i);
      #1;
      checks++; if (c_s_tready !== (i < 4) || c_occ !== 3'(i)) begin errors++;
        $display("FAIL fill_%0d got rdy%b occ%0d expected rdy%b occ%0d", i, c_s_tready, c_occ, i < 4, i); end
      tick();
    end
    checks++; if (c_occ !== 3'd4 || c_s_tready !== 1'b0 || c_m_tvalid !== 1'b1 || c_m_tdata !== 64'h21) begin
      errors++; $display("FAIL fill_hold got occ%0d rdy%b v%b %h expected occ4 rdy0 v1 21",
                         c_occ, c_s_tready, c_m_tvalid, c_m_tdata); end
  endtask

  // From full, sink ready and source streaming 0x25..0x29: occupancy 4 then steady 3, order kept.
  task automatic test_back_to_back();
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(64'h21 + 64'(i));
    c_m_tready = 1'b1;
    #1;
    checks++; if (c_occ !== 3'd4 || c_s_tready !== 1'b0 || c_m_tdata !== exp_q[0]) begin errors++;
      $display("FAIL b2b_full got occ%0d rdy%b %h expected occ4 rdy0 %h", c_occ, c_s_tready, c_m_tdata, exp_q[0]); end
    void'(exp_q.pop_front());
    tick();
    for (int k = 1; k < 9; k++) begin
      logic [63:0] exp_head;
      logic [2:0]  exp_occ;
      c_s_tvalid = (k < 6); c_s_tdata = 64'h24 + 64'(k);
      exp_occ  = (k < 7) ? 3'd3 : 3'(9 - k);
      exp_head = exp_q.pop_front();
      #1;
      checks++; if (c_occ !== exp_occ || c_m_tvalid !== 1'b1 || c_m_tdata !== exp_head) begin errors++;
        $display("FAIL b2b_%0d got occ%0d v%b %h expected occ%0d v1 %h", k, c_occ, c_m_tvalid, c_m_tdata, exp_occ, exp_head); end
      tick();
    end
    checks++; if (c_m_tvalid !== 1'b0 || c_occ !== 3'd0 || exp_q.size() != 0) begin errors++;
      $display("FAIL b2b_drained got v%b occ%0d left%0d expected v0 occ0 left0", c_m_tvalid, c_occ, exp_q.size()); end
  endtask

  // Store-and-forward: A,B,C(tlast) are held back until the cycle after C is written.
  task automatic test_packet();
    p_m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_s_tvalid = 1'b1; p_s_tdata = 64'h31 + 64'(i); p_s_tlast = (i == 2); p_s_tdest = 2'd2;
      #1;
      checks++; if (p_m_tvalid !== 1'b0 || p_occ !== 3'(i)) begin errors++;
        $display("FAIL pkt_hold%0d got v%b occ%0d expected v0 occ%0d", i, p_m_tvalid, p_occ, i); end
      tick();
    end
    p_s_tvalid = 1'b0; p_s_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (p_m_tvalid !== 1'b1 || p_m_tdata !== 64'h31 + 64'(i) || p_m_tlast !== (i == 2) ||
                    p_occ !== 3'(3 - i)) begin errors++;
        $display("FAIL pkt_out%0d got v%b %h l%b occ%0d expected v1 %h l%b occ%0d",
                 i, p_m_tvalid, p_m_tdata, p_m_tlast, p_occ, 64'h31 + 64'(i), i == 2, 3 - i); end
      tick();
    end
    checks++; if (p_m_tvalid !== 1'b0 || p_occ !== 3'd0 || p_ovs !== 1'b0) begin errors++;
      $display("FAIL pkt_done got v%b occ%0d ovs%b expected v0 occ0 ovs0", p_m_tvalid, p_occ, p_ovs); end
  endtask

  // Six-beat packet through a 4-deep store-and-forward FIFO: forced release, flag set, nothing lost.
  task automatic test_oversize();
    int idx  = 0;
    int outs = 0;
    int cyc  = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(64'h41 + 64'(i));
    p_m_tready = 1'b1;
    while (outs < 6 && cyc < 40) begin
      logic acc;
      p_s_tvalid = (idx < 6); p_s_tdata = 64'h41 + 64'(idx); p_s_tlast = (idx == 5);
      #1;
      if (cyc == 4) begin
        checks++; if (p_m_tvalid !== 1'b1 || p_occ !== 3'd4 || p_s_tready !== 1'b0 || p_ovs !== 1'b0) begin errors++;
          $display("FAIL ovs_full got v%b occ%0d rdy%b ovs%b expected v1 occ4 rdy0 ovs0", p_m_tvalid, p_occ, p_s_tready, p_ovs); end
      end
      if (cyc == 5) begin
        checks++; if (p_m_tvalid !== 1'b0 || p_occ !== 3'd3 || p_ovs !== 1'b1) begin errors++;
          $display("FAIL ovs_flag got v%b occ%0d ovs%b expected v0 occ3 ovs1", p_m_tvalid, p_occ, p_ovs); end
      end
      if (p_m_tvalid === 1'b1) begin
        logic [63:0] exp_d;
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD;
        checks++; if (p_m_tdata !== exp_d) begin errors++;
          $display("FAIL ovs_beat%0d got %h expected %h", outs, p_m_tdata, exp_d); end
        outs++;
      end
      acc = p_s_tvalid && p_s_tready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    p_s_tvalid = 1'b0;
    #1;
    checks++; if (outs != 6 || p_occ !== 3'd0 || p_m_tvalid !== 1'b0 || p_ovs !== 1'b1) begin errors++;
      $display("FAIL ovs_end got outs%0d occ%0d v%b ovs%b expected outs6 occ0 v0 ovs1", outs, p_occ, p_m_tvalid, p_ovs); end
    tick();
  endtask

  // Reset with three beats stored discards them and clears the sticky oversize flag.
  task automatic test_reset_mid();
    c_m_tready = 1'b0; c_s_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_s_tvalid = 1'b1; c_s_tdata = 64'h51 + 64'(i);
      tick();
    end
    c_s_tvalid = 1'b0;
    #1;
    checks++; if (c_occ !== 3'd3 || c_m_tdata !== 64'h51) begin errors++;
      $display("FAIL rst_mid_pre got occ%0d %h expected occ3 51", c_occ, c_m_tdata); end
    areset = 1'b1;
    #1;
    checks++; if (c_s_tready !== 1'b0) begin errors++;
      $display("FAIL rst_mid_tready got %b expected 0", c_s_tready); end
    tick();
    areset = 1'b0;
    #1;
    checks++; if (c_occ !== 3'd0 || c_m_tvalid !== 1'b0 || c_m_tdata !== 64'h0 || c_m_tlast !== 1'b0) begin errors++;
      $display("FAIL rst_mid_post got occ%0d v%b %h l%b expected occ0 v0 0 l0", c_occ, c_m_tvalid, c_m_tdata, c_m_tlast); end
    checks++; if (p_ovs !== 1'b0 || p_occ !== 3'd0 || c_s_tready !== 1'b1) begin errors++;
      $display("FAIL rst_mid_flags got ovs%b occ%0d rdy%b expected ovs0 occ0 rdy1", p_ovs, p_occ, c_s_tready); end
  endtask

  initial begin
    test_reset();
    test_cut_through();
    test_fill();
    test_back_to_back();
    test_packet();
    test_oversize();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
